// File: rtl/corelet_ctrl_if.sv
// Host/L0 <-> corelet_ctrl signal bundle.
// Optional perf counters present when CORELET_CTRL_PERF_EN is defined.
interface corelet_ctrl_if #(
  parameter int unsigned addr_bw = 11,
  parameter int unsigned len_bw  = 8
);
  logic               start;
  logic [addr_bw-1:0] w_base;
  logic [addr_bw-1:0] x_base;
  logic [len_bw-1:0]  x_len;
  logic               l0_full;
  logic               l0_ready;
  logic               mem_rd;
  logic [addr_bw-1:0] mem_addr;
  logic               l0_wr;
  logic               l0_rd;
  logic               load;
  logic               execute;
  logic               busy;
  logic               done;
`ifdef CORELET_CTRL_PERF_EN
  logic [15:0]        stall_cnt;
  logic [15:0]        full_cnt;

  modport master (
    output start, w_base, x_base, x_len, l0_full, l0_ready,
    input  mem_rd, mem_addr, l0_wr, l0_rd, load, execute, busy, done, stall_cnt, full_cnt
  );
  modport slave (
    input  start, w_base, x_base, x_len, l0_full, l0_ready,
    output mem_rd, mem_addr, l0_wr, l0_rd, load, execute, busy, done, stall_cnt, full_cnt
  );
`else
  modport master (
    output start, w_base, x_base, x_len, l0_full, l0_ready,
    input  mem_rd, mem_addr, l0_wr, l0_rd, load, execute, busy, done
  );
  modport slave (
    input  start, w_base, x_base, x_len, l0_full, l0_ready,
    output mem_rd, mem_addr, l0_wr, l0_rd, load, execute, busy, done
  );
`endif
endinterface

// File: rtl/corelet_ctrl.sv
// Corelet pass sequencer: weight staging/load, activation streaming, drain.
// Optional macro CORELET_CTRL_PERF_EN adds saturating stall_cnt/full_cnt outputs.
module corelet_ctrl #(
  parameter int unsigned row     = 8,
  parameter int unsigned col     = 8,
  parameter int unsigned addr_bw = 11,
  parameter int unsigned len_bw  = 8
) (
  input logic             clk,
  input logic             reset,
  corelet_ctrl_if.slave   bus
);

  localparam int unsigned cnt_bw = ($clog2(col + 1) > len_bw) ? $clog2(col + 1) : len_bw;
  localparam int unsigned tmr_bw = $clog2(row + col + 3);

  typedef enum logic [2:0] {
    StIdle,
    StPhW,
    StWaitW,
    StPhX,
    StDrain,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [cnt_bw-1:0]  fcnt_q, fcnt_d;
  logic [cnt_bw-1:0]  rcnt_q, rcnt_d;
  logic [tmr_bw-1:0]  tmr_q, tmr_d;
  logic [addr_bw-1:0] w_base_q, x_base_q;
  logic [len_bw-1:0]  x_len_q;
  logic               l0_wr_q;
  logic               latch_en;

  logic               in_phase;
  logic [cnt_bw-1:0]  tgt;
  logic [addr_bw-1:0] base;
  logic               fetch_go;
  logic               read_go;

  assign in_phase = (state_q == StPhW) || (state_q == StPhX);
  assign tgt      = (state_q == StPhW) ? cnt_bw'(col) : cnt_bw'(x_len_q);
  assign base     = (state_q == StPhW) ? w_base_q : x_base_q;
  assign fetch_go = in_phase && (fcnt_q < tgt) && !bus.l0_full;
  assign read_go  = in_phase && (rcnt_q < tgt) && bus.l0_ready;

  // Next-state and per-phase counter logic
  always_comb begin
    state_d  = state_q;
    fcnt_d   = fcnt_q + cnt_bw'(fetch_go);
    rcnt_d   = rcnt_q + cnt_bw'(read_go);
    tmr_d    = tmr_q;
    latch_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d  = StPhW;
          fcnt_d   = '0;
          rcnt_d   = '0;
          latch_en = 1'b1;
        end
      end
      StPhW: begin
        if (rcnt_d == tgt) begin
          state_d = StWaitW;
          tmr_d   = '0;
        end
      end
      StWaitW: begin
        tmr_d = tmr_q + 1'b1;
        if (tmr_q == tmr_bw'(row + col - 1)) begin
          state_d = (x_len_q == '0) ? StDrain : StPhX;
          fcnt_d  = '0;
          rcnt_d  = '0;
          tmr_d   = '0;
        end
      end
      StPhX: begin
        if (rcnt_d == tgt) begin
          state_d = StDrain;
          tmr_d   = '0;
        end
      end
      StDrain: begin
        tmr_d = tmr_q + 1'b1;
        if (tmr_q == tmr_bw'(row + col + 1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, counters, latched pass parameters and delayed L0 write
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      fcnt_q   <= '0;
      rcnt_q   <= '0;
      tmr_q    <= '0;
      w_base_q <= '0;
      x_base_q <= '0;
      x_len_q  <= '0;
      l0_wr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      rcnt_q  <= rcnt_d;
      tmr_q   <= tmr_d;
      // Write lands one cycle after the fetch, even across a phase change
      l0_wr_q <= fetch_go;
      if (latch_en) begin
        w_base_q <= bus.w_base;
        x_base_q <= bus.x_base;
        x_len_q  <= bus.x_len;
      end
    end
  end

  // Outputs are forced low while reset is held
  assign bus.mem_rd   = fetch_go && !reset;
  assign bus.mem_addr = (in_phase && !reset) ? base + addr_bw'(fcnt_q) : '0;
  assign bus.l0_wr    = l0_wr_q && !reset;
  assign bus.l0_rd    = read_go && !reset;
  assign bus.load     = read_go && (state_q == StPhW) && !reset;
  assign bus.execute  = read_go && (state_q == StPhX) && !reset;
  assign bus.busy     = (state_q != StIdle) && !reset;
  assign bus.done     = (state_q == StDone) && !reset;

`ifdef CORELET_CTRL_PERF_EN
  logic [15:0] stall_q, full_q;
  logic        stall_hit, full_hit;

  assign stall_hit = in_phase && (rcnt_q < tgt) && !bus.l0_ready;
  assign full_hit  = in_phase && (fcnt_q < tgt) && bus.l0_full;

  // Saturating perf counters, cleared when a pass is accepted
  always_ff @(posedge clk) begin
    if (reset || ((state_q == StIdle) && bus.start)) begin
      stall_q <= '0;
      full_q  <= '0;
    end else begin
      if (stall_hit && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
      if (full_hit && (full_q != 16'hFFFF))   full_q  <= full_q + 16'd1;
    end
  end

  assign bus.stall_cnt = reset ? 16'd0 : stall_q;
  assign bus.full_cnt  = reset ? 16'd0 : full_q;
`endif

endmodule

// File: tb/tb_corelet_ctrl.sv
// Randomised self-checking bench for corelet_ctrl with a behavioural pass model
// and a simple L0 FIFO environment. Honours CORELET_CTRL_PERF_EN.
module tb_corelet_ctrl;
  localparam int ROW = 8;
  localparam int COL = 8;
  localparam int ABW = 11;
  localparam int LBW = 8;
  localparam int AMOD = 1 << ABW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  corelet_ctrl_if #(.addr_bw(ABW), .len_bw(LBW)) bus ();

  corelet_ctrl #(.row(ROW), .col(COL), .addr_bw(ABW), .len_bw(LBW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Driven pass parameters
  int drv_wb, drv_xb, drv_len;

  // L0 environment
  int   depth;
  int   l0_q[$];
  logic pend_v;
  int   pend_a;
  logic force_low;
  int   drop_pct;

  // Behavioural model: stage 0 idle, 1 weights, 2 gap, 3 activations, 4 drain, 5 done
  int   st, fetched, consumed, timer, m_wb, m_xb, m_nx;
  logic m_prev_rd;
  int   m_stall, m_full;

  // Per-pass observations
  int loads, execs, dones, last_exec_cyc, first_exec_cyc, last_load_cyc, done_cyc, max_gap;
  int fetch_log[$];
  int pop_log[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic tick(input logic s, input logic r);
    logic full, rdy, phase, e_mem_rd, e_rd;
    int   tgt, base;
    @(negedge clk);
    reset        = r;
    bus.start    = s;
    bus.w_base   = ABW'(drv_wb);
    bus.x_base   = ABW'(drv_xb);
    bus.x_len    = LBW'(drv_len);
    full         = (l0_q.size() + int'(pend_v)) >= depth;
    rdy          = (l0_q.size() > 0) && !force_low &&
                   !((drop_pct > 0) && ($urandom_range(99) < drop_pct));
    bus.l0_full  = full;
    bus.l0_ready = rdy;
    #1;
    phase    = (st == 1) || (st == 3);
    tgt      = (st == 1) ? COL : m_nx;
    base     = (st == 1) ? m_wb : m_xb;
    e_mem_rd = !r && phase && (fetched < tgt) && !full;
    e_rd     = !r && phase && (consumed < tgt) && rdy;
    check("mem_rd", int'(bus.mem_rd), int'(e_mem_rd));
    if (e_mem_rd) check("mem_addr", int'(bus.mem_addr), (base + fetched) % AMOD);
    if (r) check("mem_addr_rst", int'(bus.mem_addr), 0);
    check("l0_wr", int'(bus.l0_wr), int'(!r && m_prev_rd));
    check("l0_rd", int'(bus.l0_rd), int'(e_rd));
    check("load", int'(bus.load), int'(e_rd && st == 1));
    check("execute", int'(bus.execute), int'(e_rd && st == 3));
    check("busy", int'(bus.busy), int'(!r && st != 0));
    check("done", int'(bus.done), int'(!r && st == 5));
`ifdef CORELET_CTRL_PERF_EN
    check("stall_cnt", int'(bus.stall_cnt), r ? 0 : m_stall);
    check("full_cnt", int'(bus.full_cnt), r ? 0 : m_full);
`endif
    // Observations
    if (bus.load) begin
      loads++;
      last_load_cyc = cyc;
    end
    if (bus.execute) begin
      if (execs == 0) first_exec_cyc = cyc;
      else if (cyc - last_exec_cyc - 1 > max_gap) max_gap = cyc - last_exec_cyc - 1;
      execs++;
      last_exec_cyc = cyc;
    end
    if (bus.done) begin
      dones++;
      done_cyc = cyc;
    end
    if (bus.mem_rd) fetch_log.push_back(int'(bus.mem_addr));
    // L0 environment follows the DUT strobes
    if (r) begin
      l0_q.delete();
      pend_v = 1'b0;
    end else begin
      if (bus.l0_rd && l0_q.size() > 0) pop_log.push_back(l0_q.pop_front());
      if (bus.l0_wr && pend_v) l0_q.push_back(pend_a);
      pend_v = bus.mem_rd;
      pend_a = int'(bus.mem_addr);
    end
    // Model advance
    if (r) begin
      st = 0; fetched = 0; consumed = 0; timer = 0;
      m_prev_rd = 1'b0; m_stall = 0; m_full = 0;
    end else begin
      if (st == 0 && s) begin
        m_stall = 0;
        m_full  = 0;
      end else begin
        if (phase && consumed < tgt && !rdy && m_stall < 65535) m_stall++;
        if (phase && fetched < tgt && full && m_full < 65535) m_full++;
      end
      m_prev_rd = e_mem_rd;
      if (e_mem_rd) fetched++;
      if (e_rd) consumed++;
      case (st)
        0: if (s) begin
          st = 1; fetched = 0; consumed = 0;
          m_wb = drv_wb % AMOD; m_xb = drv_xb % AMOD; m_nx = drv_len % (1 << LBW);
        end
        1: if (consumed == COL) begin st = 2; timer = 0; end
        2: begin
          timer++;
          if (timer == ROW + COL) begin
            st = (m_nx == 0) ? 4 : 3; fetched = 0; consumed = 0; timer = 0;
          end
        end
        3: if (consumed == m_nx) begin st = 4; timer = 0; end
        4: begin
          timer++;
          if (timer == ROW + COL + 2) st = 5;
        end
        default: st = 0;
      endcase
    end
    cyc++;
  endtask

  // mode: 0 plain, 1 forced 5-cycle ready drop, 2 start while busy, 3 reset mid PH_X
  task automatic run_pass(input int mode, input int wb, input int xb, input int xl,
                          input int dep, input int drop);
    logic s, r, aborted, sent;
    int   stall_used, bad;
    depth = dep; drop_pct = drop; force_low = 1'b0;
    drv_wb = wb; drv_xb = xb; drv_len = xl;
    loads = 0; execs = 0; dones = 0; max_gap = 0;
    last_exec_cyc = 0; first_exec_cyc = 0; last_load_cyc = 0; done_cyc = 0;
    fetch_log.delete(); pop_log.delete();
    aborted = 1'b0; sent = 1'b0; stall_used = 0;
    tick(1'b1, 1'b0);
    // Inputs change after the latch edge; the pass must not see it
    drv_wb = int'($urandom_range(AMOD - 1));
    drv_xb = int'($urandom_range(AMOD - 1));
    drv_len = int'($urandom_range(255));
    for (int k = 0; k < 4000 && dones == 0 && !aborted; k++) begin
      s = 1'b0; r = 1'b0;
      if (mode == 1) begin
        force_low = (execs >= 2) && (stall_used < 5);
        if (force_low) stall_used++;
      end
      if (mode == 2 && st == 3 && !sent) begin
        s = 1'b1; drv_wb = 100; drv_xb = 300; drv_len = 3; sent = 1'b1;
      end
      if (mode == 3 && st == 3 && execs == 5 && !sent) begin
        r = 1'b1; sent = 1'b1; aborted = 1'b1;
      end
      tick(s, r);
    end
    force_low = 1'b0;
    if (mode == 3) begin
      tick(1'b0, 1'b0);
      check("abort_busy", int'(bus.busy), 0);
      check("abort_no_done", dones, 0);
      check("abort_reached", int'(aborted), 1);
      return;
    end
    check("pass_completed", int'(dones > 0), 1);
    check("load_count", loads, COL);
    check("exec_count", execs, xl);
    check("done_count", dones, 1);
    if (xl > 0) check("exec_to_done", done_cyc - last_exec_cyc, ROW + COL + 3);
    bad = 0;
    for (int i = 0; i < COL + xl; i++) begin
      int exp_a;
      exp_a = (i < COL) ? (wb + i) % AMOD : (xb + i - COL) % AMOD;
      if (i >= fetch_log.size() || fetch_log[i] != exp_a) bad++;
      if (i >= pop_log.size() || pop_log[i] != exp_a) bad++;
    end
    check("fetch_len", fetch_log.size(), COL + xl);
    check("addr_seq_errs", bad, 0);
  endtask

  initial begin
    drv_wb = 0; drv_xb = 0; drv_len = 0;
    depth = 16; drop_pct = 0; force_low = 1'b0; pend_v = 1'b0; pend_a = 0;
    st = 0; fetched = 0; consumed = 0; timer = 0; m_wb = 0; m_xb = 0; m_nx = 0;
    m_prev_rd = 1'b0; m_stall = 0; m_full = 0;
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_mem_rd", int'(bus.mem_rd), 0);
    check("reset_done", int'(bus.done), 0);

    // Nominal pass, ideal L0
    run_pass(0, 0, 64, 16, 16, 0);
    check("nominal_load_to_exec", first_exec_cyc - last_load_cyc, ROW + COL + 3);
    check("nominal_exec_span", last_exec_cyc - first_exec_cyc, 15);
    tick(1'b0, 1'b0);
    check("idle_after_done", int'(bus.busy), 0);

    // Backpressure with a forced 5-cycle ready drop
    run_pass(1, 16, 500, 20, 4, 0);
    check("stall_gap", max_gap, 5);

    // Zero length
    run_pass(0, 8, 200, 0, 16, 0);

    // Start while busy, then back-to-back start on the cycle after done
    run_pass(2, 32, 1000, 10, 16, 0);
    run_pass(0, 48, 1100, 6, 16, 0);

    // Reset mid PH_X, then a clean pass
    run_pass(3, 0, 64, 16, 16, 0);
    run_pass(0, 0, 64, 16, 16, 0);

    // Address wrap
    run_pass(0, 2044, 2046, 5, 16, 0);
    check("wrap_w4", fetch_log.size() > 4 ? fetch_log[4] : -1, 0);
    check("wrap_x2", fetch_log.size() > 10 ? fetch_log[10] : -1, 0);

    // Randomised passes
    for (int p = 0; p < 6; p++) begin
      run_pass(0, int'($urandom_range(AMOD - 1)), int'($urandom_range(AMOD - 1)),
               int'($urandom_range(40)), int'($urandom_range(16, 2)),
               int'($urandom_range(30)));
      for (int g = 0; g < int'($urandom_range(3)); g++) tick(1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
